imem_line_responder: RTL
========================

// Module: imem_line_responder
// PURPOSE
//  Instruction-memory responder on the fetch side of the IF stage: receives the
//  combinational fetch address (Instr_address_2IM) and returns the instruction
//  word (Instr1_fIM) one cycle later. Holds one LINE_WORDS-word line buffer; on
//  a miss it stalls fetch (imem_stall -> IF FREEZE) and burst-fills the line
//  from backing memory over a req/ack handshake.
// PARAMETERS
//  LINE_WORDS   4             words per line; power of 2, >= 2
//  NULL_INSTR   32'h00000000  value driven on Instr1_fIM at reset and flush
// PORTS
//  CLK               in   1   clock, all state updates on posedge
//  RESET             in   1   asynchronous, active-high reset
//  Instr_address_2IM in   32  fetch byte address from IF; bits [1:0] ignored
//  flush             in   1   invalidate line buffer (e.g. after self-modifying store)
//  Instr1_fIM        out  32  registered instruction word for previous cycle's address
//  imem_stall        out  1   1 = Instr1_fIM not valid next cycle; IF must hold
//  mem_req           out  1   backing-memory read request, one word per beat
//  mem_addr          out  32  word-aligned address of current beat
//  mem_ack           in   1   beat accepted; mem_rdata valid same cycle
//  mem_rdata         in   32  backing-memory read data
// BEHAVIOUR
//  - Reset (async, RESET=1): state=IDLE, line valid=0, tag=0, beat cnt=0,
//    Instr1_fIM=NULL_INSTR, mem_req=0, mem_addr=0. Buffer contents don't-care.
//  - base = {addr[31:log2(LINE_WORDS)+2], 0}; hit = valid && base==tag && state==IDLE.
//  - imem_stall (comb) = (state!=IDLE) || !hit. After reset: 1 until first fill.
//  - IDLE: hit -> at posedge Instr1_fIM <= buf[addr word index]; latency 1 cycle.
//    miss -> latch fill_base=base, cnt=0, go FILL; Instr1_fIM holds.
//  - FILL: mem_req=1 (registered), mem_addr=fill_base+4*cnt. Each cycle with
//    mem_req&&mem_ack: buf[cnt]<=mem_rdata, cnt++. ack with mem_req=0 ignored.
//    mem_ack may stay low indefinitely; stall held. Ack on last beat
//    (cnt==LINE_WORDS-1): mem_req<=0, valid<=1, tag<=fill_base, go DONE.
//  - DONE: one cycle, stall=1; back to IDLE, where the (held) address now hits
//    and its word is registered at the next posedge.
//  - Miss-to-data latency: 1 (IDLE) + LINE_WORDS ack beats + 1 (DONE) + 1.
//  - Address changes during FILL/DONE are ignored (IF is frozen); IDLE re-evaluates.
//  - flush (highest priority after RESET): at posedge valid<=0, mem_req<=0,
//    cnt<=0, state<=IDLE, Instr1_fIM<=NULL_INSTR; an ack in that same cycle is
//    dropped. Next cycle misses and refetches.
//  - mem_addr wraps modulo 2^32 (no carry out); cnt width = log2(LINE_WORDS).
//  - RESET mid-fill: all state cleared immediately, mem_req drops asynchronously.
// TESTING
//  1 Reset then addr=0x100, mem_ack=1 always, mem_rdata=0xA0+beat -> beats at
//    0x100,0x104,0x108,0x10C; stall high 6 cycles; then Instr1_fIM=0xA0.
//  2 After T1, addrs 0x104,0x10C,0x100 back-to-back -> no stall, Instr1_fIM
//    0xA1,0xA3,0xA0 each one cycle after its address.
//  3 addr=0x110 (other line) with mem_ack pulsing every 3rd cycle -> mem_req
//    held, 4 beats at 0x110..0x11C, tag=0x110, old line no longer hits.
//  4 flush asserted on 2nd beat of fill -> mem_req drops next cycle,
//    Instr1_fIM=0, stall stays 1, fill restarts at beat 0 of same base.
//  5 RESET pulsed mid-fill (async, between edges) -> mem_req=0, Instr1_fIM=0
//    immediately; after release first fetch misses.
//  6 addr=0xFFFFFFF0, LINE_WORDS=4 -> beats 0xFFFFFFF0..0xFFFFFFFC, no wrap
//    error; addr bits[1:0]=2'b11 returns same word as 2'b00.

Source files
------------

// File: rtl/imem_line_responder.sv
// Instruction-memory responder: single-line buffer in front of a req/ack backing memory.
// Hits return the addressed word one cycle later; misses stall IF while the line burst-fills.
module imem_line_responder #(
  parameter int          LINE_WORDS = 4,
  parameter logic [31:0] NULL_INSTR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr_address_2IM,
  input  logic        flush,
  output logic [31:0] Instr1_fIM,
  output logic        imem_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int OFF_W = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t             state, state_next;
  logic               line_valid;
  logic [31:0]        tag;
  logic [31:0]        fill_base;
  logic [OFF_W-1:0]   cnt;
  logic [31:0]        line_buf [LINE_WORDS];

  logic [31:0]        base;
  logic [OFF_W-1:0]   word_idx;
  logic               hit;
  logic               beat;
  logic               last_beat;
  logic               unused_addr_bits;

  assign base             = {Instr_address_2IM[31:OFF_W+2], {(OFF_W+2){1'b0}}};
  assign word_idx         = Instr_address_2IM[OFF_W+1:2];
  assign unused_addr_bits = ^Instr_address_2IM[1:0];

  assign hit        = line_valid && (base == tag) && (state == IDLE);
  assign imem_stall = (state != IDLE) || !hit;
  assign beat       = (state == FILL) && mem_req && mem_ack;
  assign last_beat  = beat && (cnt == OFF_W'(LINE_WORDS - 1));

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (!hit) state_next = FILL;
        FILL:    if (last_beat) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      line_valid <= 1'b0;
      tag        <= '0;
      fill_base  <= '0;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      Instr1_fIM <= NULL_INSTR;
    end else if (flush) begin
      // A beat acked in the flush cycle is dropped; the refill starts again at word 0.
      line_valid <= 1'b0;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= fill_base;
      Instr1_fIM <= NULL_INSTR;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            Instr1_fIM <= line_buf[word_idx];
          end else begin
            fill_base <= base;
            cnt       <= '0;
            mem_req   <= 1'b1;
            mem_addr  <= base;
          end
        end
        FILL: begin
          if (beat) begin
            cnt <= cnt + 1'b1;
            if (last_beat) begin
              mem_req    <= 1'b0;
              mem_addr   <= fill_base;
              line_valid <= 1'b1;
              tag        <= fill_base;
            end else begin
              mem_addr <= mem_addr + 32'd4;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the line storage is deliberately not reset; line_valid guards every read of it.
  always_ff @(posedge CLK) begin
    if (beat && !flush) line_buf[cnt] <= mem_rdata;
  end

endmodule
